// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests an instruction, issues it for decode, then drives
// the PC with an increment, a jump or a return popped from a small return-address stack.
module fetch_sequencer #(
    parameter int STACK_DEPTH = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        halt,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        instr_valid,
    input  logic        branch_req,
    input  logic        call_req,
    input  logic        ret_req,
    input  logic [15:0] target,
    input  logic [15:0] pc_value,
    output logic        controle,
    output logic        hab_jump,
    output logic [15:0] jump_pc,
    output logic        busy,
    output logic        stack_ovf,
    output logic        stack_unf,
    output logic        mem_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_UPDATE,
        S_HALTED
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [15:0]        stack_q [STACK_DEPTH];
    logic [15:0]        stack_d [STACK_DEPTH];
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               err_q, err_d;
    logic [15:0]        jump_pc_q, jump_pc_d;
    logic               controle_q, controle_d;
    logic               hab_jump_q, hab_jump_d;
    logic               mem_req_q, mem_req_d;
    logic               instr_valid_q, instr_valid_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   top_idx;
    logic [IDX_W-1:0]   push_idx;

    assign top_idx  = IDX_W'(sp_q - SP_W'(1));
    assign push_idx = IDX_W'(sp_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sp_d       = sp_q;
        stack_d    = stack_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        err_d      = err_q;
        jump_pc_d  = jump_pc_q;
        controle_d = 1'b0;
        hab_jump_d = 1'b0;

        case (state_q)
            S_IDLE, S_HALTED: begin
                // In HALTED a simultaneous halt keeps the sequencer parked.
                if (start && !(state_q == S_HALTED && halt)) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                // Redirect inputs are captured here; the PC controls they produce appear during UPDATE.
                state_d = S_UPDATE;
                if (ret_req) begin
                    if (sp_q == '0) begin
                        unf_d      = 1'b1;
                        controle_d = 1'b1;
                    end else begin
                        sp_d       = sp_q - SP_W'(1);
                        hab_jump_d = 1'b1;
                        jump_pc_d  = stack_q[top_idx];
                    end
                end else if (call_req) begin
                    hab_jump_d = 1'b1;
                    jump_pc_d  = target;
                    if (sp_q == SP_W'(STACK_DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        stack_d[push_idx] = pc_value + 16'd1;
                        sp_d              = sp_q + SP_W'(1);
                    end
                end else if (branch_req) begin
                    hab_jump_d = 1'b1;
                    jump_pc_d  = target;
                end else begin
                    controle_d = 1'b1;
                end
            end
            S_UPDATE: begin
                cnt_d   = '0;
                state_d = halt ? S_HALTED : S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        mem_req_d     = (state_d == S_FETCH);
        instr_valid_d = (state_d == S_ISSUE);
        busy_d        = (state_d == S_FETCH) || (state_d == S_ISSUE) || (state_d == S_UPDATE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            sp_q          <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
            err_q         <= 1'b0;
            jump_pc_q     <= '0;
            controle_q    <= 1'b0;
            hab_jump_q    <= 1'b0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sp_q          <= sp_d;
            stack_q       <= stack_d;
            ovf_q         <= ovf_d;
            unf_q         <= unf_d;
            err_q         <= err_d;
            jump_pc_q     <= jump_pc_d;
            controle_q    <= controle_d;
            hab_jump_q    <= hab_jump_d;
            mem_req_q     <= mem_req_d;
            instr_valid_q <= instr_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign instr_valid = instr_valid_q;
    assign controle    = controle_q;
    assign hab_jump    = hab_jump_q;
    assign jump_pc     = jump_pc_q;
    assign busy        = busy_q;
    assign stack_ovf   = ovf_q;
    assign stack_unf   = unf_q;
    assign mem_err     = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer; a queue-based return-stack model predicts every
// PC control pulse, jump address and sticky flag.
module tb_fetch_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic        clock      = 1'b0;
    logic        reset_n    = 1'b0;
    logic        start      = 1'b0;
    logic        halt       = 1'b0;
    logic        mem_ack    = 1'b0;
    logic        branch_req = 1'b0;
    logic        call_req   = 1'b0;
    logic        ret_req    = 1'b0;
    logic [15:0] target     = 16'h0;
    logic [15:0] pc_value   = 16'h0;
    logic        mem_req, instr_valid, controle, hab_jump, busy;
    logic        stack_ovf, stack_unf, mem_err;
    logic [15:0] jump_pc;

    fetch_sequencer #(.STACK_DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .halt       (halt),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .instr_valid(instr_valid),
        .branch_req (branch_req),
        .call_req   (call_req),
        .ret_req    (ret_req),
        .target     (target),
        .pc_value   (pc_value),
        .controle   (controle),
        .hab_jump   (hab_jump),
        .jump_pc    (jump_pc),
        .busy       (busy),
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf),
        .mem_err    (mem_err)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] ref_stack [$];
    bit          ref_ovf, ref_unf, ref_err;
    logic [15:0] ref_jump = 16'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_ovf"}, stack_ovf, ref_ovf);
        check({tag, "_unf"}, stack_unf, ref_unf);
        check({tag, "_err"}, mem_err, ref_err);
    endtask

    task automatic model_reset();
        ref_stack.delete();
        ref_ovf  = 0;
        ref_unf  = 0;
        ref_err  = 0;
        ref_jump = 16'h0;
    endtask

    // From IDLE or HALTED: start clears the sticky flags and enters FETCH.
    task automatic restart();
        halt  = 1'b0;
        start = 1'b1;
        tick();
        start   = 1'b0;
        ref_ovf = 0;
        ref_unf = 0;
        ref_err = 0;
        check("restart_memreq", mem_req, 1);
        check("restart_busy", busy, 1);
        check_flags("restart");
    endtask

    // Called in the first FETCH cycle; leaves the bench in the cycle after UPDATE.
    task automatic run_instr(input int delay, input bit r, input bit c, input bit b,
                             input logic [15:0] tgt, input logic [15:0] pc, input bit h);
        bit exp_ctl, exp_hab;
        halt = h;
        for (int i = 0; i < delay; i++) begin
            check("fetch_memreq", mem_req, 1);
            check("fetch_no_valid", instr_valid, 0);
            tick();
        end
        mem_ack = 1'b1;
        check("ack_memreq", mem_req, 1);
        tick();
        mem_ack = 1'b0;
        check("issue_valid", instr_valid, 1);
        check("issue_memreq", mem_req, 0);
        check("issue_busy", busy, 1);
        ret_req    = r;
        call_req   = c;
        branch_req = b;
        target     = tgt;
        pc_value   = pc;

        exp_ctl = 0;
        exp_hab = 0;
        if (r) begin
            if (ref_stack.size() == 0) begin
                ref_unf = 1;
                exp_ctl = 1;
            end else begin
                exp_hab  = 1;
                ref_jump = ref_stack.pop_back();
            end
        end else if (c) begin
            exp_hab  = 1;
            ref_jump = tgt;
            if (ref_stack.size() == DEPTH) ref_ovf = 1;
            else ref_stack.push_back(16'(pc + 16'd1));
        end else if (b) begin
            exp_hab  = 1;
            ref_jump = tgt;
        end else begin
            exp_ctl = 1;
        end

        tick();
        ret_req    = 1'b0;
        call_req   = 1'b0;
        branch_req = 1'b0;
        target     = 16'($urandom);
        pc_value   = 16'($urandom);
        $display("instr r=%0b c=%0b b=%0b tgt=%h pc=%h halt=%0b -> controle=%0b hab_jump=%0b jump_pc=%h depth=%0d",
                 r, c, b, tgt, pc, h, controle, hab_jump, jump_pc, ref_stack.size());
        check("update_controle", controle, exp_ctl);
        check("update_hab_jump", hab_jump, exp_hab);
        check("update_jump_pc", jump_pc, ref_jump);
        check("update_busy", busy, 1);
        check_flags("update");
        tick();
        check("post_controle", controle, 0);
        check("post_hab_jump", hab_jump, 0);
        check("post_jump_hold", jump_pc, ref_jump);
        if (h) begin
            check("halted_busy", busy, 0);
            check("halted_memreq", mem_req, 0);
        end else begin
            check("next_fetch_memreq", mem_req, 1);
        end
        halt = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_memreq", mem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_controle", controle, 0);
        check("rst_hab_jump", hab_jump, 0);
        check("rst_jump_pc", jump_pc, 16'h0);
        check("rst_busy", busy, 0);
        check_flags("rst");
        reset_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);
        restart();

        // Sequential fetches with ack two cycles after the request.
        run_instr(2, 0, 0, 0, 16'h1111, 16'h0005, 0);
        run_instr(2, 0, 0, 0, 16'h2222, 16'h0006, 0);

        // Call then return.
        run_instr(2, 0, 1, 0, 16'h0040, 16'h0010, 0);
        run_instr(1, 0, 0, 1, 16'h0077, 16'h0040, 0);
        run_instr(0, 1, 0, 0, 16'h0099, 16'h0078, 0);

        // Overflow then underflow.
        for (int i = 0; i < 5; i++)
            run_instr(1, 0, 1, 0, 16'(16'h0100 + i), 16'(16'h0A00 + i), 0);
        for (int i = 0; i < 5; i++)
            run_instr(1, 1, 0, 0, 16'h0, 16'h0, 0);

        // Return address wraps at the top of the address space.
        run_instr(0, 0, 1, 0, 16'h0300, 16'hFFFF, 0);
        run_instr(0, 1, 0, 0, 16'h0000, 16'h0300, 0);

        // All redirects with halt: return wins, then park.
        run_instr(1, 0, 1, 0, 16'h0100, 16'h0200, 0);
        run_instr(1, 1, 1, 1, 16'h0300, 16'h0400, 1);
        start = 1'b1;
        halt  = 1'b1;
        tick();
        check("halt_prio_busy", busy, 0);
        check("halt_prio_memreq", mem_req, 0);
        start = 1'b0;
        restart();

        // Ack timeout.
        for (int i = 0; i < TMO; i++) begin
            check("tmo_memreq", mem_req, 1);
            tick();
        end
        ref_err = 1;
        check("tmo_busy", busy, 0);
        check("tmo_memreq_off", mem_req, 0);
        check_flags("tmo");
        restart();

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            bit          r, c, b, h;
            logic [15:0] pc;
            r  = ($urandom_range(0, 9) < 3);
            c  = ($urandom_range(0, 9) < 3);
            b  = ($urandom_range(0, 9) < 3);
            h  = ($urandom_range(0, 11) == 0);
            pc = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            run_instr(int'($urandom_range(0, 4)), r, c, b, 16'($urandom), pc, h);
            if (h) restart();
        end

        // Asynchronous reset in the middle of a FETCH with flags set.
        for (int i = 0; i < DEPTH + 1; i++)
            run_instr(0, 0, 1, 0, 16'(16'h0500 + i), 16'(16'h0600 + i), 0);
        check("prereset_ovf", stack_ovf, 1);
        check("prereset_memreq", mem_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("arst_memreq", mem_req, 0);
        check("arst_busy", busy, 0);
        check("arst_jump_pc", jump_pc, 16'h0);
        check_flags("arst");
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("arst_no_controle", controle, 0);
            check("arst_no_hab_jump", hab_jump, 0);
        end
        mem_ack = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("after_rst_busy", busy, 0);
        restart();
        run_instr(1, 1, 0, 0, 16'h0, 16'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 4, number of return-address stack entries (2..8).
REQ-002 Parameter ACK_TIMEOUT, default 15, maximum cycles FETCH waits for mem_ack before error.
REQ-003 clock  in  1  single system clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  level; starts or resumes fetching from IDLE or HALTED.
REQ-006 halt  in  1  level; requests stop after the current instruction.
REQ-007 mem_req  out  1  instruction-memory read request.
REQ-008 mem_ack  in  1  memory returns the instruction this cycle.
REQ-009 instr_valid  out  1  one-cycle pulse; the fetched instruction is valid for decode.
REQ-010 branch_req  in  1  taken-branch redirect, sampled only while instr_valid=1.
REQ-011 call_req  in  1  subroutine call, sampled only while instr_valid=1.
REQ-012 ret_req  in  1  subroutine return, sampled only while instr_valid=1.
REQ-013 target  in  16  branch/call destination address.
REQ-014 pc_value  in  16  current program counter value.
REQ-015 controle  out  1  PC increment enable.
REQ-016 hab_jump  out  1  PC load enable.
REQ-017 jump_pc  out  16  PC load value.
REQ-018 busy  out  1  high in any state other than IDLE and HALTED.
REQ-019 stack_ovf  out  1  sticky flag; a call was made with the stack full.
REQ-020 stack_unf  out  1  sticky flag; a return was made with the stack empty.
REQ-021 mem_err  out  1  sticky flag; an ACK_TIMEOUT expired.

Function
REQ-022 The FSM SHALL have the states IDLE, FETCH, ISSUE, UPDATE and HALTED.
REQ-023 In IDLE or HALTED with start=1, the FSM SHALL clear all sticky flags and enter FETCH on the next edge.
REQ-024 In FETCH, mem_req SHALL be 1 and a wait counter SHALL increment each cycle.
- mem_ack=1: counter clears; enter ISSUE.
- Counter reaches ACK_TIMEOUT with no ack: set mem_err; enter IDLE.
REQ-025 ISSUE SHALL last exactly one cycle with instr_valid=1, and the redirect inputs SHALL be registered on that cycle.
REQ-026 Registered redirect priority SHALL be ret_req > call_req > branch_req > sequential.
REQ-027 UPDATE SHALL last exactly one cycle, asserting exactly one of controle or hab_jump.
- sequential: controle=1.
- branch: hab_jump=1, jump_pc=target.
- call: hab_jump=1, jump_pc=target; pc_value+1 (mod 2^16) pushed.
- return: hab_jump=1, jump_pc=popped entry.
REQ-028 A call with the stack full SHALL set stack_ovf, discard the push (stack unchanged) and still jump.
REQ-029 A return with the stack empty SHALL set stack_unf and perform a sequential increment (controle=1).
REQ-030 jump_pc SHALL hold its last value whenever hab_jump=0.
REQ-031 After UPDATE, the FSM SHALL enter HALTED if halt=1, otherwise FETCH.
REQ-032 halt asserted in FETCH or ISSUE SHALL NOT abort the in-flight instruction.
REQ-033 In HALTED, start=1 and halt=1 asserted together SHALL give priority to halt (remain HALTED).
REQ-034 pc_value+1 at 16'hFFFF SHALL wrap to 16'h0000.
REQ-035 The stack contents and pointer SHALL persist across HALTED and IDLE and SHALL be cleared only by reset.
REQ-036 Outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-037 reset_n=0 SHALL immediately force state IDLE.
REQ-038 reset_n=0 SHALL immediately force all outputs to 0, including jump_pc=16'h0000.
REQ-039 reset_n=0 SHALL immediately clear the stack pointer, the wait counter and all sticky flags.
REQ-040 Reset asserted mid-FETCH SHALL drop mem_req asynchronously, and the FSM SHALL produce no UPDATE pulse after reset.

Verification
REQ-041 Sequential fetch: start=1, mem_ack 2 cycles after each mem_req -> repeating FETCH(3)/ISSUE/UPDATE with controle=1, hab_jump=0.
REQ-042 Call/return: call_req with target=16'h0040, pc_value=16'h0010 -> jump_pc=16'h0040; a later ret_req -> jump_pc=16'h0011.
REQ-043 Overflow/underflow: 5 calls with STACK_DEPTH=4 -> stack_ovf=1 and the 5th return address is lost; 5 returns -> stack_unf=1, the 5th return is a controle pulse.
REQ-044 Timeout: mem_ack held 0 -> mem_ack=0 for 15 cycles -> mem_err=1, state IDLE, busy=0; then start=1 -> mem_err cleared.
REQ-045 Priority/halt: ret_req, call_req and branch_req all high with halt=1 -> return taken, then HALTED with busy=0.
REQ-046 Async reset: reset_n low mid-FETCH -> mem_req=0 before the next edge; stack and flags cleared.
